tl_conflict_monitor: RTL
========================

// Module: tl_conflict_monitor
// PURPOSE
//  Safety stage directly downstream of the traffic-light controller. Samples its six lamp outputs,
//  passes legal patterns to the lamp drivers with 1-cycle latency, and on any illegal pattern or
//  sequence latches a fault and forces flashing-red on both approaches until acknowledged and
//  the controller shows a stable all-red.
// PARAMETERS
//  MIN_YELLOW     4   minimum consecutive yellow cycles before yellow may drop (per approach)
//  FLASH_HALF     8   cycles per flash half-period (on, then off)
//  RECOVER_CYCLES 8   consecutive all-red input cycles required to leave RECOVER
// PORTS
//  clk          in   1  single clock, all logic on posedge
//  clear_n      in   1  synchronous, active-low reset
//  RED_NS_i, YELLOW_NS_i, GREEN_NS_i, RED_WE_i, YELLOW_WE_i, GREEN_WE_i  in  1 each  from controller
//  fault_ack    in   1  1-cycle pulse, honoured only in FLASH
//  RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE, GREEN_WE  out  1 each  registered lamp drives
//  fault        out  1  high from fault latch until return to NORMAL
//  fault_code   out  3  first-detected fault code; 0 = none
// BEHAVIOUR
//  Reset (clear_n=0 at posedge): RED_NS=RED_WE=1, other lamps 0, fault=0, fault_code=0,
//   state=NORMAL, prev-input reg=all-red, yellow counters=0, flash counter=0, phase=on.
//  Checks on current raw inputs vs prev-input reg (prev reg updates every cycle, all states):
//   1 NS not one-hot; 2 WE not one-hot; 3 conflict: NS and WE both non-red;
//   4 short yellow: prev yellow=1, now 0, yellow count < MIN_YELLOW;
//   5 green skip: prev green=1, now red=1 on same approach. Multiple hits -> lowest code.
//  Yellow counter per approach: +1 each cycle input yellow=1, saturates at MIN_YELLOW, 0 when yellow=0.
//  States:
//   NORMAL: no hit -> outputs <= inputs (latency 1). Hit -> same edge: state<=FLASH, fault<=1,
//    fault_code<=code, outputs<=flash-on pattern; illegal pattern never reaches outputs.
//   FLASH: counter 0..FLASH_HALF-1, phase toggles on wrap; first FLASH cycle is phase on.
//    on = flash pattern, off = all lamps 0. Further hits ignored; first code held.
//    fault_ack=1 -> state<=RECOVER, outputs<=all-red solid.
//   RECOVER: outputs all-red solid; count consecutive cycles input == all-red (no hit); any other
//    input restarts count (not a fault). Count reaches RECOVER_CYCLES -> NORMAL, fault<=0,
//    fault_code<=0, outputs<=inputs that edge.
//  fault_ack outside FLASH ignored. Reset mid-FLASH/RECOVER: immediate return to reset values.
//  Counters sized $clog2(param+1); no wrap beyond terminal value.
// CONFIGURATION
//  FLASH_YELLOW_NS_EN defined: flash-on pattern = YELLOW_NS=1, RED_WE=1 (NS as main road).
//  Undefined: flash-on pattern = RED_NS=1, RED_WE=1. Off phase all 0 in both builds.
// STRUCTURE
//  Package tl_pkg: state enum {NORMAL, FLASH, RECOVER}; fault-code constants
//   FC_NONE..FC_GREEN_SKIP (3-bit); 6-bit lamp pattern constants ALL_RED, ALL_OFF, FLASH_ON.
//  Sub-module tl_flash_gen: flash counter + phase, inputs clk/clear_n/enable, output phase_on.
// TESTING
//  1 Controller model 30/4/4 timing, two full cycles -> outputs = inputs delayed 1, fault=0 throughout.
//  2 GREEN_NS_i=GREEN_WE_i=1 (reds 0) -> next edge fault=1, code=3, RED_NS=RED_WE=1 for 8 cycles,
//    then all 0 for 8, repeating; GREEN lamps never seen high.
//  3 YELLOW_NS_i for 2 cycles then RED_NS_i -> code=4 at edge RED arrives; with MIN_YELLOW cycles -> no fault.
//  4 GREEN_NS_i directly to RED_NS_i -> code=5; simultaneous codes 3+5 -> code=3.
//  5 In FLASH pulse fault_ack, give 7 all-red, 1 NS-green, 8 all-red -> NORMAL, fault=0, code=0
//    exactly on 8th consecutive all-red edge.
//  6 clear_n=0 one cycle mid-FLASH -> next edge all-red solid, fault=0, code=0; repeat with
//    FLASH_YELLOW_NS_EN -> flash-on shows YELLOW_NS=1, RED_WE=1.

Source files
------------

// File: rtl/tl_pkg.sv
// tl_pkg: shared states, fault codes and lamp patterns for the conflict monitor.
// FLASH_YELLOW_NS_EN selects a yellow-NS / red-WE flash pattern instead of red on both approaches.
package tl_pkg;
   typedef enum logic [1:0] {NORMAL, FLASH, RECOVER} state_t;
   localparam logic [2:0] FC_NONE         = 3'd0;
   localparam logic [2:0] FC_NS_ONEHOT    = 3'd1;
   localparam logic [2:0] FC_WE_ONEHOT    = 3'd2;
   localparam logic [2:0] FC_CONFLICT     = 3'd3;
   localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
   localparam logic [2:0] FC_GREEN_SKIP   = 3'd5;
   // lamp bit order: {RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE, GREEN_WE}
   localparam logic [5:0] ALL_RED = 6'b100_100;
   localparam logic [5:0] ALL_OFF = 6'b000_000;
`ifdef FLASH_YELLOW_NS_EN
   localparam logic [5:0] FLASH_ON = 6'b010_100;
`else
   localparam logic [5:0] FLASH_ON = 6'b100_100;
`endif
   function automatic logic [2:0] first_code(input logic [4:0] hits);
      return hits[0] ? FC_NS_ONEHOT :
             hits[1] ? FC_WE_ONEHOT :
             hits[2] ? FC_CONFLICT :
             hits[3] ? FC_SHORT_YELLOW :
             hits[4] ? FC_GREEN_SKIP : FC_NONE;
   endfunction
endpackage

// File: rtl/tl_flash_gen.sv
// tl_flash_gen: flash half-period counter and phase; phase_on is the phase the lamps show after this edge.
module tl_flash_gen
   import tl_pkg::*;
#(
   parameter int FLASH_HALF = 8
) (
   input  logic clk,
   input  logic clear_n,
   input  logic enable,
   output logic phase_on
);
   localparam int CW = $clog2(FLASH_HALF + 1);
   localparam logic [CW-1:0] C_LAST = CW'(FLASH_HALF - 1);
   logic [CW-1:0] cnt;
   logic phase;
   logic wrap;
   assign wrap = cnt == C_LAST;
   assign phase_on = phase ^ wrap;
   always_ff @(posedge clk)
      if (!clear_n || !enable) begin
         cnt <= '0;
         phase <= 1'b1;
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         phase <= phase_on;
      end
endmodule

// File: rtl/tl_conflict_monitor.sv
// tl_conflict_monitor: passes legal lamp patterns through one register, latches faults and flashes until recovery.
// FLASH_YELLOW_NS_EN changes the flash-on pattern to yellow NS with red WE.
module tl_conflict_monitor
   import tl_pkg::*;
#(
   parameter int MIN_YELLOW     = 4,
   parameter int FLASH_HALF     = 8,
   parameter int RECOVER_CYCLES = 8
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       RED_NS_i,
   input  logic       YELLOW_NS_i,
   input  logic       GREEN_NS_i,
   input  logic       RED_WE_i,
   input  logic       YELLOW_WE_i,
   input  logic       GREEN_WE_i,
   input  logic       fault_ack,
   output logic       RED_NS,
   output logic       YELLOW_NS,
   output logic       GREEN_NS,
   output logic       RED_WE,
   output logic       YELLOW_WE,
   output logic       GREEN_WE,
   output logic       fault,
   output logic [2:0] fault_code
);
   localparam int YW = $clog2(MIN_YELLOW + 1);
   localparam int RW = $clog2(RECOVER_CYCLES + 1);
   localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW);
   localparam logic [RW-1:0] R_LAST = RW'(RECOVER_CYCLES - 1);
   state_t state;
   logic [5:0] in_lamps, prev, lamps;
   logic [YW-1:0] y_ns, y_we;
   logic [RW-1:0] rec_cnt;
   logic [4:0] hits;
   logic [2:0] code;
   logic phase_on;
   assign in_lamps = {RED_NS_i, YELLOW_NS_i, GREEN_NS_i, RED_WE_i, YELLOW_WE_i, GREEN_WE_i};
   assign {RED_NS, YELLOW_NS, GREEN_NS, RED_WE, YELLOW_WE, GREEN_WE} = lamps;
   assign hits = {
      (prev[3] && in_lamps[5]) || (prev[0] && in_lamps[2]),
      (prev[4] && !in_lamps[4] && y_ns < Y_MAX) || (prev[1] && !in_lamps[1] && y_we < Y_MAX),
      !in_lamps[5] && !in_lamps[2],
      !$onehot(in_lamps[2:0]),
      !$onehot(in_lamps[5:3])
   };
   assign code = first_code(hits);
   tl_flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
      .clk      (clk),
      .clear_n  (clear_n),
      .enable   (state == FLASH),
      .phase_on (phase_on)
   );
   always_ff @(posedge clk)
      if (!clear_n) begin
         state <= NORMAL;
         lamps <= ALL_RED;
         fault <= 1'b0;
         fault_code <= FC_NONE;
         prev <= ALL_RED;
         y_ns <= '0;
         y_we <= '0;
         rec_cnt <= '0;
      end else begin
         prev <= in_lamps;
         y_ns <= !in_lamps[4] ? '0 : y_ns == Y_MAX ? y_ns : y_ns + 1'b1;
         y_we <= !in_lamps[1] ? '0 : y_we == Y_MAX ? y_we : y_we + 1'b1;
         case (state)
            NORMAL:
               if (code != FC_NONE) begin
                  state <= FLASH;
                  fault <= 1'b1;
                  fault_code <= code;
                  lamps <= FLASH_ON;
               end else
                  lamps <= in_lamps;
            FLASH:
               if (fault_ack) begin
                  state <= RECOVER;
                  lamps <= ALL_RED;
                  rec_cnt <= '0;
               end else
                  lamps <= phase_on ? FLASH_ON : ALL_OFF;
            // lamps stay solid red; only an unbroken all-red run releases the latch
            RECOVER:
               if (in_lamps != ALL_RED)
                  rec_cnt <= '0;
               else if (rec_cnt == R_LAST) begin
                  state <= NORMAL;
                  fault <= 1'b0;
                  fault_code <= FC_NONE;
                  lamps <= in_lamps;
                  rec_cnt <= '0;
               end else
                  rec_cnt <= rec_cnt + 1'b1;
            default: state <= NORMAL;
         endcase
      end
endmodule
